// File: rtl/stopwatch_bcd_ctrl.sv
// Stopwatch controller: synchronised DIP/button inputs driving a NUM_DIGITS-digit
// BCD up/down counter with a prescaled run tick and a digit-serial constant adder.
module stopwatch_bcd_ctrl #(
  parameter int NUM_DIGITS = 2,
  parameter int TICK_DIV   = 1,
  parameter int ADD_VALUE  = 5,
  parameter int DOWN_START = 30,
  parameter int SATURATE   = 0
) (
  input  logic                    clk,
  input  logic                    push_reset,
  input  logic                    dip_enable,
  input  logic                    dip_up,
  input  logic                    push_add,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    busy,
  output logic                    terminal,
  output logic                    add_ovf
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam bit SAT = (SATURATE != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, ADD = 2'd3} state_t;

  function automatic logic [W-1:0] to_bcd(input int value);
    logic [W-1:0] r;
    int v;
    r = {W{1'b0}};
    v = value;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] d);
    logic [W-1:0] r;
    logic c;
    r = d;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (d[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = d[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] d);
    logic [W-1:0] r;
    logic b;
    r = d;
    b = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b) begin
        if (d[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
        else begin
          r[4*i +: 4] = d[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  localparam logic [W-1:0] ADDEND    = to_bcd(ADD_VALUE);
  localparam logic [W-1:0] DOWN_BCD  = to_bcd(DOWN_START);
  localparam logic [W-1:0] ALL_NINES = {NUM_DIGITS{4'd9}};
  localparam logic [W-1:0] ZERO      = {W{1'b0}};

  state_t        state_r, state_nx;
  logic          en_meta, en_s, up_meta, up_s, add_meta, add_s, add_prev;
  logic          add_req, tick, last_digit, add_cout, term_raw;
  logic [W-1:0]  digits_r, digits_nx, shadow_r, shadow_nx, shadow_upd;
  logic [PW-1:0] presc_r, presc_nx;
  logic [IW-1:0] idx_r, idx_nx;
  logic [IW+1:0] sel;
  logic [4:0]    dsum;
  logic [3:0]    new_dig;
  logic          carry_r, carry_nx, ovf_r, ovf_nx;

  // Two-flop synchronisers plus the previous add_s sample for edge detection.
  always_ff @(posedge clk or negedge push_reset) begin
    if (!push_reset) begin
      en_meta  <= 1'b0;
      en_s     <= 1'b0;
      up_meta  <= 1'b1;
      up_s     <= 1'b1;
      add_meta <= 1'b1;
      add_s    <= 1'b1;
      add_prev <= 1'b1;
    end else begin
      en_meta  <= dip_enable;
      en_s     <= en_meta;
      up_meta  <= dip_up;
      up_s     <= up_meta;
      add_meta <= push_add;
      add_s    <= add_meta;
      add_prev <= add_s;
    end
  end

  assign add_req    = add_prev & ~add_s;
  assign tick       = (presc_r == PW'(TICK_DIV - 1));
  assign last_digit = (idx_r == IW'(NUM_DIGITS - 1));
  assign sel        = {idx_r, 2'b00};
  assign term_raw   = (up_s && digits_r == ALL_NINES) || (!up_s && digits_r == ZERO);

  // One BCD digit of the serial add; sums 10..19 wrap mod 16 back onto 0..9.
  always_comb begin
    dsum       = {1'b0, shadow_r[sel +: 4]} + {1'b0, ADDEND[sel +: 4]} + {4'd0, carry_r};
    add_cout   = (dsum > 5'd9);
    if (add_cout) new_dig = dsum[3:0] - 4'd10;
    else          new_dig = dsum[3:0];
    shadow_upd = shadow_r;
    shadow_upd[sel +: 4] = new_dig;
  end

  // State register.
  always_ff @(posedge clk or negedge push_reset) begin
    if (!push_reset) state_r <= IDLE;
    else             state_r <= state_nx;
  end

  // Next-state logic; a pending add outranks resuming from PAUSE.
  always_comb begin
    state_nx = IDLE;
    case (state_r)
      IDLE:    if (en_s) state_nx = RUN;   else state_nx = IDLE;
      RUN:     if (en_s) state_nx = RUN;   else state_nx = PAUSE;
      PAUSE:   if (add_req) state_nx = ADD;
               else if (en_s) state_nx = RUN;
               else state_nx = PAUSE;
      ADD:     if (last_digit) state_nx = PAUSE; else state_nx = ADD;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath next values: count steps, prescaler, and the shadowed serial add.
  always_comb begin
    digits_nx = digits_r;
    shadow_nx = shadow_r;
    presc_nx  = {PW{1'b0}};
    idx_nx    = {IW{1'b0}};
    carry_nx  = 1'b0;
    ovf_nx    = 1'b0;
    case (state_r)
      IDLE: begin
        if (en_s && !up_s) digits_nx = DOWN_BCD;
        else               digits_nx = ZERO;
      end
      RUN: begin
        if (!en_s)      digits_nx = digits_r;
        else if (!tick) presc_nx  = presc_r + PW'(1);
        else if (up_s) begin
          if (SAT && digits_r == ALL_NINES) digits_nx = digits_r;
          else                              digits_nx = bcd_inc(digits_r);
        end else begin
          if (SAT && digits_r == ZERO) digits_nx = digits_r;
          else                         digits_nx = bcd_dec(digits_r);
        end
      end
      PAUSE: shadow_nx = digits_r;
      ADD: begin
        shadow_nx = shadow_upd;
        idx_nx    = idx_r + IW'(1);
        carry_nx  = add_cout;
        if (last_digit) begin
          ovf_nx = add_cout;
          if (SAT && add_cout) digits_nx = ALL_NINES;
          else                 digits_nx = shadow_upd;
        end else begin
          digits_nx = digits_r;
        end
      end
      default: digits_nx = ZERO;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge push_reset) begin
    if (!push_reset) begin
      digits_r <= ZERO;
      shadow_r <= ZERO;
      presc_r  <= {PW{1'b0}};
      idx_r    <= {IW{1'b0}};
      carry_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      digits_r <= digits_nx;
      shadow_r <= shadow_nx;
      presc_r  <= presc_nx;
      idx_r    <= idx_nx;
      carry_r  <= carry_nx;
      ovf_r    <= ovf_nx;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    running  = 1'b0;
    busy     = 1'b0;
    terminal = 1'b0;
    case (state_r)
      IDLE:    terminal = 1'b0;
      RUN:     begin running = 1'b1; terminal = term_raw; end
      PAUSE:   terminal = term_raw;
      ADD:     begin busy = 1'b1; terminal = term_raw; end
      default: terminal = 1'b0;
    endcase
  end

  assign digits  = digits_r;
  assign add_ovf = ovf_r;

endmodule
